// File: rtl/param_cpu_pkg.sv
// Shared opcode and FSM state definitions for the param_accum_cpu accumulator processor.
// Optional feature macro: PARAM_CPU_SAT_EN (used by param_cpu_alu).
package param_cpu_pkg;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_IN    = 3'b100;
  localparam logic [2:0] OP_JZ    = 3'b101;
  localparam logic [2:0] OP_JPOS  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    INWAIT = 3'd3,
    HALTED = 3'd4
  } state_t;

endpackage

// File: rtl/param_cpu_alu.sv
// Add/subtract unit for param_accum_cpu.
// PARAM_CPU_SAT_EN defined: signed saturating arithmetic; undefined: modulo wrap.
module param_cpu_alu #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          sub,
  output logic [DW-1:0] result
);

`ifdef PARAM_CPU_SAT_EN
  logic [DW-1:0] b_eff;
  logic [DW-1:0] raw;
  logic          ovf;

  always_comb begin
    b_eff = sub ? ~b : b;
    raw   = a + b_eff + {{(DW-1){1'b0}}, sub};
    // Overflow: both addends share a sign that the sum does not carry
    ovf   = (a[DW-1] == b_eff[DW-1]) && (raw[DW-1] != a[DW-1]);
    if (ovf)
      result = a[DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    else
      result = raw;
  end
`else
  always_comb begin
    result = sub ? (a - b) : (a + b);
  end
`endif

endmodule

// File: rtl/param_accum_cpu.sv
// Multi-cycle accumulator CPU with unified program/data RAM and reset-time program port.
// Build option PARAM_CPU_SAT_EN selects saturating ADD/SUB in param_cpu_alu.
module param_accum_cpu
  import param_cpu_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 5
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Enable,
  input  logic          Enter,
  input  logic [DW-1:0] Input,
  input  logic          ProgWe,
  input  logic [AW-1:0] ProgAddr,
  input  logic [DW-1:0] ProgData,
  output logic          Halt,
  output logic          InWait,
  output logic [DW-1:0] Output
);

  localparam int DEPTH = 2**AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] pc;
  logic [DW-1:0] ir;
  logic [DW-1:0] acc;
  logic          enter_q;
  state_t        state;

  logic [2:0]    opcode;
  logic [AW-1:0] addr;
  logic [DW-1:0] mem_rd;
  logic [DW-1:0] alu_res;
  logic          alu_sub;
  logic          unused_ir;

  assign opcode    = ir[DW-1:DW-3];
  assign addr      = ir[AW-1:0];
  assign mem_rd    = mem[addr];
  assign alu_sub   = (opcode == OP_SUB);
  assign unused_ir = ^ir;

  param_cpu_alu #(.DW(DW)) u_alu (
    .a      (acc),
    .b      (mem_rd),
    .sub    (alu_sub),
    .result (alu_res)
  );

  // Program port only writes while held in reset; STORE only writes when running
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      if (ProgWe) mem[ProgAddr] <= ProgData;
    end else if (Enable && (state == EXEC) && (opcode == OP_STORE)) begin
      mem[addr] <= acc;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      pc      <= '0;
      ir      <= '0;
      acc     <= '0;
      Output  <= '0;
      Halt    <= 1'b0;
      InWait  <= 1'b0;
      enter_q <= 1'b1;
      state   <= FETCH;
    end else if (Enable) begin
      enter_q <= Enter;
      case (state)
        FETCH: begin
          ir    <= mem[pc];
          pc    <= pc + AW'(1);
          state <= DECODE;
        end
        DECODE: begin
          case (opcode)
            OP_IN: begin
              InWait <= 1'b1;
              state  <= INWAIT;
            end
            OP_HALT: begin
              Halt  <= 1'b1;
              state <= HALTED;
            end
            default: state <= EXEC;
          endcase
        end
        EXEC: begin
          case (opcode)
            OP_LOAD: begin
              acc    <= mem_rd;
              Output <= mem_rd;
            end
            OP_ADD, OP_SUB: begin
              acc    <= alu_res;
              Output <= alu_res;
            end
            OP_JZ:   if (acc == '0) pc <= addr;
            OP_JPOS: if (!acc[DW-1] && (acc != '0)) pc <= addr;
            default: ;
          endcase
          state <= FETCH;
        end
        INWAIT: begin
          if (Enter && !enter_q) begin
            acc    <= Input;
            Output <= Input;
            InWait <= 1'b0;
            state  <= FETCH;
          end
        end
        HALTED: ;
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_param_accum_cpu.sv
// Directed bench for param_accum_cpu: single-op vector table plus multi-cycle sequences.
module tb_param_accum_cpu;

  logic       Clock = 1'b0;
  logic       Reset, Enable, Enter, ProgWe;
  logic [7:0] Input, ProgData;
  logic [4:0] ProgAddr;
  logic       Halt, InWait;
  logic [7:0] Output;

  logic        Reset2, Enable2, Enter2, ProgWe2;
  logic [11:0] Input2, ProgData2;
  logic [5:0]  ProgAddr2;
  logic        Halt2, InWait2;
  logic [11:0] Output2;

  int errors = 0;
  int checks = 0;

  always #5 Clock = ~Clock;

  param_accum_cpu #(.DW(8), .AW(5)) dut (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .Enter(Enter), .Input(Input),
    .ProgWe(ProgWe), .ProgAddr(ProgAddr), .ProgData(ProgData),
    .Halt(Halt), .InWait(InWait), .Output(Output)
  );

  param_accum_cpu #(.DW(12), .AW(6)) dut2 (
    .Clock(Clock), .Reset(Reset2), .Enable(Enable2), .Enter(Enter2), .Input(Input2),
    .ProgWe(ProgWe2), .ProgAddr(ProgAddr2), .ProgData(ProgData2),
    .Halt(Halt2), .InWait(InWait2), .Output(Output2)
  );

  typedef struct {
    logic [7:0] i1;
    logic [7:0] i2;
    logic [7:0] a0;
    logic [7:0] b;
    logic [7:0] exp_out;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic step(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic load(input logic [4:0] ad, input logic [7:0] d);
    Reset = 1'b0; ProgWe = 1'b1; ProgAddr = ad; ProgData = d;
    step(1);
    ProgWe = 1'b0;
  endtask

  task automatic load2(input logic [5:0] ad, input logic [11:0] d);
    Reset2 = 1'b0; ProgWe2 = 1'b1; ProgAddr2 = ad; ProgData2 = d;
    step(1);
    ProgWe2 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int decs;
    logic [7:0] prev;

    Reset = 1'b0; Enable = 1'b1; Enter = 1'b0; Input = 8'h00;
    ProgWe = 1'b0; ProgAddr = '0; ProgData = '0;
    Reset2 = 1'b0; Enable2 = 1'b1; Enter2 = 1'b0; Input2 = '0;
    ProgWe2 = 1'b0; ProgAddr2 = '0; ProgData2 = '0;

    // i1, i2, M30 (initial A), M31, expected Output
    vecs[0]  = '{8'h5F, 8'hE0, 8'h05, 8'h07, 8'h0C};  // ADD
    vecs[1]  = '{8'h7F, 8'hE0, 8'h10, 8'h03, 8'h0D};  // SUB
    vecs[2]  = '{8'h5F, 8'hE0, 8'h01, 8'hFF, 8'h00};  // ADD wrap
    vecs[3]  = '{8'h7F, 8'hE0, 8'h00, 8'h01, 8'hFF};  // SUB underflow
`ifdef PARAM_CPU_SAT_EN
    vecs[4]  = '{8'h5F, 8'hE0, 8'h7F, 8'h01, 8'h7F};
    vecs[5]  = '{8'h7F, 8'hE0, 8'h80, 8'h01, 8'h80};
`else
    vecs[4]  = '{8'h5F, 8'hE0, 8'h7F, 8'h01, 8'h80};
    vecs[5]  = '{8'h7F, 8'hE0, 8'h80, 8'h01, 8'h7F};
`endif
    vecs[6]  = '{8'h1F, 8'hE0, 8'h00, 8'hA5, 8'hA5};  // LOAD
    vecs[7]  = '{8'h3F, 8'h5F, 8'h21, 8'h99, 8'h42};  // STORE then ADD same word
    vecs[8]  = '{8'hA4, 8'h1D, 8'h00, 8'h00, 8'h00};  // JZ taken
    vecs[9]  = '{8'hA4, 8'h1D, 8'h03, 8'h00, 8'h55};  // JZ not taken
    vecs[10] = '{8'hC4, 8'h1D, 8'h01, 8'h00, 8'h01};  // JPOS taken
    vecs[11] = '{8'hC4, 8'h1D, 8'h80, 8'h00, 8'h55};  // JPOS negative
    vecs[12] = '{8'hC4, 8'h1D, 8'h00, 8'h00, 8'h55};  // JPOS zero

    step(2);
    chk("reset_output", Output, 0);
    chk("reset_halt", Halt, 0);
    chk("reset_inwait", InWait, 0);

    for (int i = 0; i < NV; i++) begin
      load(0, 8'h1E); load(1, vecs[i].i1); load(2, vecs[i].i2);
      load(3, 8'hE0); load(4, 8'hE0);
      load(29, 8'h55); load(30, vecs[i].a0); load(31, vecs[i].b);
      Reset = 1'b1;
      step(12);
      chk($sformatf("vec%0d_halt", i), Halt, 1);
      chk($sformatf("vec%0d_output", i), Output, vecs[i].exp_out);
    end

    // LOAD 30; ADD 31; STORE 29; HALT
    load(0, 8'h1E); load(1, 8'h5F); load(2, 8'h3D); load(3, 8'hE0);
    load(29, 8'h00); load(30, 8'h05); load(31, 8'h07);
    Reset = 1'b1;
    step(10);
    chk("prog1_halt_early", Halt, 0);
    step(1);
    chk("prog1_halt", Halt, 1);
    chk("prog1_output", Output, 8'h0C);
    chk("prog1_m29", dut.mem[29], 8'h0C);

    // IN; HALT with Enter held from reset
    Enter = 1'b1; Input = 8'h2A;
    load(0, 8'h80); load(1, 8'hE0);
    Reset = 1'b1;
    step(2);
    chk("in_wait_set", InWait, 1);
    step(3);
    chk("in_held_wait", InWait, 1);
    chk("in_held_a", Output, 0);
    Enter = 1'b0;
    step(1);
    chk("in_release_wait", InWait, 1);
    Enter = 1'b1;
    step(1);
    chk("in_edge_a", Output, 8'h2A);
    chk("in_edge_wait", InWait, 0);
    step(1);
    chk("in_halt_early", Halt, 0);
    step(1);
    chk("in_halt", Halt, 1);
    Enter = 1'b0;

    // Countdown: LOAD 30; SUB 31; JZ 4; JPOS 1; HALT
    load(0, 8'h1E); load(1, 8'h7F); load(2, 8'hA4); load(3, 8'hC1); load(4, 8'hE0);
    load(30, 8'h03); load(31, 8'h01);
    Reset = 1'b1;
    decs = 0; prev = Output;
    for (int c = 0; c < 28; c++) begin
      step(1);
      if (Output < prev) decs++;
      prev = Output;
    end
    chk("count_halt_early", Halt, 0);
    step(1);
    chk("count_iters", decs, 3);
    chk("count_halt", Halt, 1);
    chk("count_output", Output, 0);

    // Freeze in EXEC of ADD; ProgWe while running must be ignored
    load(0, 8'h1E); load(1, 8'h5F); load(2, 8'h3D); load(3, 8'hE0);
    load(30, 8'h05); load(31, 8'h07);
    Reset = 1'b1;
    step(5);
    Enable = 1'b0; ProgWe = 1'b1; ProgAddr = 5'd31; ProgData = 8'h00; Enter = 1'b1;
    step(5);
    chk("freeze_pc", dut.pc, 2);
    chk("freeze_a", Output, 8'h05);
    chk("freeze_state", dut.state, 2);
    Enable = 1'b1; ProgWe = 1'b0; Enter = 1'b0;
    step(1);
    chk("resume_a", Output, 8'h0C);
    step(4);
    chk("resume_halt_early", Halt, 0);
    step(1);
    chk("resume_halt", Halt, 1);

    // Reset during INWAIT while loading HALT at address 0
    load(0, 8'h1E); load(1, 8'h80); load(30, 8'h33);
    Reset = 1'b1;
    step(5);
    chk("abort_wait", InWait, 1);
    chk("abort_a", Output, 8'h33);
    Reset = 1'b0; ProgWe = 1'b1; ProgAddr = 5'd0; ProgData = 8'hE0;
    step(1);
    chk("abort_out", Output, 0);
    chk("abort_inwait", InWait, 0);
    chk("abort_halt", Halt, 0);
    Reset = 1'b1; ProgWe = 1'b0;
    step(1);
    chk("abort_halt_1", Halt, 0);
    step(1);
    chk("abort_halt_2", Halt, 1);

    // DW=12, AW=6 instance
    load2(0, 12'h03E); load2(1, 12'h43F); load2(2, 12'h23D); load2(3, 12'hE00);
    load2(62, 12'h123); load2(63, 12'h456);
    Reset2 = 1'b1;
    step(10);
    chk("w12_halt_early", Halt2, 0);
    step(1);
    chk("w12_halt", Halt2, 1);
    chk("w12_output", Output2, 12'h579);
    chk("w12_m61", dut2.mem[61], 12'h579);
    load2(0, 12'h800);
    Reset2 = 1'b1;
    step(2);
    chk("w12_inwait", InWait2, 1);
    Reset2 = 1'b0; ProgWe2 = 1'b1; ProgAddr2 = 6'd0; ProgData2 = 12'hE00;
    step(1);
    chk("w12_abort_inwait", InWait2, 0);
    Reset2 = 1'b1; ProgWe2 = 1'b0;
    step(2);
    chk("w12_abort_halt", Halt2, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
